bp_fe_mem_resp_tracker: RTL and testbench

Parametrised front-end fetch tracking pipeline. It accepts fetch commands and carries each one through a configurable-latency tag/data pipeline. It qualifies each fetch against ITLB, PMA and icache results, with poison and flush, and buffers finished responses in a credit-protected FIFO so the fetch stage may stall. It sits between the PC-generation stage and the ITLB/icache, and supports multi-instruction fetch via a per-lane valid mask.

---
 rtl/bp_fe_mem_resp_tracker.sv | 268 ++++++++++++++++++++++++++
 tb/tb_bp_fe_mem_resp_tracker.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_mem_resp_tracker.sv
// bp_fe_mem_resp_tracker
//
// Tracks front-end fetches from acceptance through a latency_p-deep tag/data
// pipeline. Each fetch is qualified against the ITLB, PMA and icache results,
// and the finished response goes into a credit-protected FIFO. The fetch
// stage can therefore stall without losing responses.
//
// Ports:
//   clk_i, reset_n_i             clock, asynchronous active-low reset
//   fetch_v_i / fetch_vaddr_i    fetch command, accepted when fetch_ready_o
//   fetch_ready_o                a credit is free and no flush is in progress
//   poison_i                     kill entries in stages 1..latency_p
//   flush_i                      kill all stages and the response FIFO
//   tlb_*, ptag_i, pte_*         ITLB result, sampled while entry is in stage 1
//   uncached_i, priv_i,
//   translation_en_i,
//   uncached_mode_i              PMA / privilege state, sampled in stage 1
//   cache_data_v_i/cache_data_i  icache result, sampled in stage latency_p
//   resp_*                       FIFO head (valid/ready handshake); data
//                                outputs read zero while resp_v_o is low
module bp_fe_mem_resp_tracker #(
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned ptag_width_p  = 28,
    parameter int unsigned instr_width_p = 32,
    parameter int unsigned lanes_p       = 2,
    parameter int unsigned latency_p     = 2,
    parameter int unsigned fifo_els_p    = 4,
    parameter int unsigned did_width_p   = 3,
    parameter logic [ptag_width_p-1:0] dram_base_ptag_p = 'h80000
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,

    input  logic                               fetch_v_i,
    input  logic [vaddr_width_p-1:0]           fetch_vaddr_i,
    output logic                               fetch_ready_o,

    input  logic                               poison_i,
    input  logic                               flush_i,

    input  logic                               tlb_v_i,
    input  logic                               tlb_miss_i,
    input  logic [ptag_width_p-1:0]            ptag_i,
    input  logic                               pte_u_i,
    input  logic                               pte_x_i,
    input  logic                               uncached_i,
    input  logic [1:0]                         priv_i,
    input  logic                               translation_en_i,
    input  logic                               uncached_mode_i,

    input  logic                               cache_data_v_i,
    input  logic [lanes_p*instr_width_p-1:0]   cache_data_i,

    output logic                               resp_v_o,
    input  logic                               resp_ready_i,
    output logic [vaddr_width_p-1:0]           resp_vaddr_o,
    output logic [lanes_p*instr_width_p-1:0]   resp_data_o,
    output logic [lanes_p-1:0]                 resp_lane_v_o,
    output logic                               resp_itlb_miss_o,
    output logic                               resp_instr_access_fault_o,
    output logic                               resp_instr_page_fault_o,
    output logic                               resp_icache_miss_o
);

    localparam int unsigned data_w_lp   = lanes_p * instr_width_p;
    localparam int unsigned lg_lanes_lp = (lanes_p > 1) ? $clog2(lanes_p) : 1;
    localparam int unsigned ptr_w_lp    = $clog2(fifo_els_p);
    localparam int unsigned cnt_w_lp    = $clog2(fifo_els_p + 1);
    localparam int unsigned occ_w_lp    = $clog2(fifo_els_p + latency_p + 1);

    localparam logic [1:0] priv_u_lp = 2'd0;
    localparam logic [1:0] priv_s_lp = 2'd1;

    typedef struct packed {
        logic itlb_miss;
        logic access_fault;
        logic page_fault;
    } fault_s;

    typedef struct packed {
        logic [vaddr_width_p-1:0] vaddr;
        logic [data_w_lp-1:0]     data;
        logic [lanes_p-1:0]       lane_v;
        logic                     itlb_miss;
        logic                     access_fault;
        logic                     page_fault;
        logic                     icache_miss;
    } resp_s;

    // ------------------------------------------------------------------
    // Tag/data pipeline. Index k holds the entry that is in stage k+1.
    // ------------------------------------------------------------------
    logic                     accept;
    logic [latency_p-1:0]     stg_v_q;
    logic [vaddr_width_p-1:0] stg_vaddr_q [latency_p];

    assign accept = fetch_v_i & fetch_ready_o;

    // Poison and flush clear every occupied stage. A fetch accepted in the
    // same cycle still lands in stage 1; accept is already low under flush.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stg_v_q <= '0;
        end else begin
            stg_v_q[0] <= accept;
            for (int unsigned k = 1; k < latency_p; k++) begin
                stg_v_q[k] <= stg_v_q[k-1] & ~poison_i & ~flush_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        stg_vaddr_q[0] <= fetch_vaddr_i;
        for (int unsigned k = 1; k < latency_p; k++) begin
            stg_vaddr_q[k] <= stg_vaddr_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Stage-1 qualification. An ITLB miss masks both faults, and an
    // access fault masks the page fault.
    // ------------------------------------------------------------------
    logic   access_raw;
    logic   page_raw;
    fault_s s1_flt;

    always_comb begin
        access_raw = (uncached_mode_i & ~uncached_i)
                   | (ptag_i[ptag_width_p-1 -: did_width_p] != '0)
                   | (ptag_i < dram_base_ptag_p);
        page_raw   = translation_en_i & tlb_v_i
                   & (((priv_i == priv_s_lp) & pte_u_i)
                    | ((priv_i == priv_u_lp) & ~pte_u_i)
                    | ~pte_x_i);

        s1_flt.itlb_miss    = tlb_miss_i;
        s1_flt.access_fault = ~tlb_miss_i & access_raw;
        s1_flt.page_fault   = ~tlb_miss_i & ~access_raw & page_raw;
    end

    // Fault flags that belong to the entry in the data stage
    fault_s data_flt;

    if (latency_p == 1) begin : g_lat1
        // Stage 1 is also the data stage, so the flags are used directly
        always_comb data_flt = s1_flt;
    end else begin : g_latn
        fault_s flt_q [latency_p-1];

        always_ff @(posedge clk_i) begin
            flt_q[0] <= s1_flt;
            for (int unsigned k = 1; k < latency_p - 1; k++) begin
                flt_q[k] <= flt_q[k-1];
            end
        end

        always_comb data_flt = flt_q[latency_p-2];
    end

    // ------------------------------------------------------------------
    // Lane mask: lanes below the starting word of the fetch are invalid.
    // ------------------------------------------------------------------
    logic [lanes_p-1:0] lane_mask;

    if (lanes_p == 1) begin : g_one_lane
        always_comb lane_mask = 1'b1;
    end else begin : g_multi_lane
        logic [lg_lanes_lp-1:0] lane_idx;

        always_comb begin
            lane_idx  = stg_vaddr_q[latency_p-1][lg_lanes_lp+1:2];
            lane_mask = '0;
            for (int unsigned i = 0; i < lanes_p; i++) begin
                lane_mask[i] = (lg_lanes_lp'(i) >= lane_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Enqueue of the data-stage entry
    // ------------------------------------------------------------------
    logic  enq;
    resp_s enq_ent;

    assign enq = stg_v_q[latency_p-1] & ~poison_i & ~flush_i;

    always_comb begin
        enq_ent.vaddr        = stg_vaddr_q[latency_p-1];
        enq_ent.data         = cache_data_i;
        enq_ent.lane_v       = lane_mask;
        enq_ent.itlb_miss    = data_flt.itlb_miss;
        enq_ent.access_fault = data_flt.access_fault;
        enq_ent.page_fault   = data_flt.page_fault;
        enq_ent.icache_miss  = ~(data_flt.itlb_miss | data_flt.access_fault
                                 | data_flt.page_fault) & ~cache_data_v_i;
    end

    // ------------------------------------------------------------------
    // Response FIFO. Credits guarantee that enq never finds the FIFO full.
    // ------------------------------------------------------------------
    resp_s                mem_q [fifo_els_p];
    logic [ptr_w_lp-1:0]  wr_ptr_q;
    logic [ptr_w_lp-1:0]  rd_ptr_q;
    logic [cnt_w_lp-1:0]  cnt_q;
    logic                 deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign resp_v_o = (cnt_q != '0);
    // A dequeue that coincides with a flush is dropped with the rest
    assign deq      = resp_v_o & resp_ready_i & ~flush_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (enq) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (deq) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + cnt_w_lp'(1);
                2'b01:   cnt_q <= cnt_q - cnt_w_lp'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= enq_ent;
    end

    resp_s head;

    always_comb begin
        head = '0;
        if (resp_v_o) head = mem_q[rd_ptr_q];
    end

    assign resp_vaddr_o              = head.vaddr;
    assign resp_data_o               = head.data;
    assign resp_lane_v_o             = head.lane_v;
    assign resp_itlb_miss_o          = head.itlb_miss;
    assign resp_instr_access_fault_o = head.access_fault;
    assign resp_instr_page_fault_o   = head.page_fault;
    assign resp_icache_miss_o        = head.icache_miss;

    // ------------------------------------------------------------------
    // Credit check: every live stage plus every FIFO entry holds a credit
    // ------------------------------------------------------------------
    logic [occ_w_lp-1:0] occ;

    always_comb begin
        occ = occ_w_lp'(cnt_q);
        for (int unsigned k = 0; k < latency_p; k++) begin
            occ = occ + occ_w_lp'(stg_v_q[k]);
        end
    end

    assign fetch_ready_o = reset_n_i & (occ < occ_w_lp'(fifo_els_p)) & ~flush_i;

endmodule

// File: tb/tb_bp_fe_mem_resp_tracker.sv
// Testbench for bp_fe_mem_resp_tracker: directed fetch sequences. A queue-based
// reference model predicts fetch_ready_o and the FIFO head every cycle, and
// a set of literal checks pins the key scenarios.
module tb_bp_fe_mem_resp_tracker;

    localparam int VA  = 39;
    localparam int PT  = 28;
    localparam int IW  = 32;
    localparam int LN  = 2;
    localparam int LAT = 2;
    localparam int FE  = 4;
    localparam int DID = 3;
    localparam int DW  = LN * IW;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic            fetch_v_i;
    logic [VA-1:0]   fetch_vaddr_i;
    logic            fetch_ready_o;
    logic            poison_i, flush_i;
    logic            tlb_v_i, tlb_miss_i;
    logic [PT-1:0]   ptag_i;
    logic            pte_u_i, pte_x_i, uncached_i;
    logic [1:0]      priv_i;
    logic            translation_en_i, uncached_mode_i;
    logic            cache_data_v_i;
    logic [DW-1:0]   cache_data_i;
    logic            resp_v_o, resp_ready_i;
    logic [VA-1:0]   resp_vaddr_o;
    logic [DW-1:0]   resp_data_o;
    logic [LN-1:0]   resp_lane_v_o;
    logic            resp_itlb_miss_o, resp_instr_access_fault_o;
    logic            resp_instr_page_fault_o, resp_icache_miss_o;

    bp_fe_mem_resp_tracker #(
        .vaddr_width_p   (VA),
        .ptag_width_p    (PT),
        .instr_width_p   (IW),
        .lanes_p         (LN),
        .latency_p       (LAT),
        .fifo_els_p      (FE),
        .did_width_p     (DID),
        .dram_base_ptag_p(28'h80000)
    ) dut (
        .clk_i                    (clk_i),
        .reset_n_i                (reset_n_i),
        .fetch_v_i                (fetch_v_i),
        .fetch_vaddr_i            (fetch_vaddr_i),
        .fetch_ready_o            (fetch_ready_o),
        .poison_i                 (poison_i),
        .flush_i                  (flush_i),
        .tlb_v_i                  (tlb_v_i),
        .tlb_miss_i               (tlb_miss_i),
        .ptag_i                   (ptag_i),
        .pte_u_i                  (pte_u_i),
        .pte_x_i                  (pte_x_i),
        .uncached_i               (uncached_i),
        .priv_i                   (priv_i),
        .translation_en_i         (translation_en_i),
        .uncached_mode_i          (uncached_mode_i),
        .cache_data_v_i           (cache_data_v_i),
        .cache_data_i             (cache_data_i),
        .resp_v_o                 (resp_v_o),
        .resp_ready_i             (resp_ready_i),
        .resp_vaddr_o             (resp_vaddr_o),
        .resp_data_o              (resp_data_o),
        .resp_lane_v_o            (resp_lane_v_o),
        .resp_itlb_miss_o         (resp_itlb_miss_o),
        .resp_instr_access_fault_o(resp_instr_access_fault_o),
        .resp_instr_page_fault_o  (resp_instr_page_fault_o),
        .resp_icache_miss_o       (resp_icache_miss_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [VA-1:0] vaddr;
        int            age;     // pipeline stage the fetch currently occupies
        bit            itlb, af, pf, icm;
        logic [DW-1:0] data;
        logic [LN-1:0] lane;
    } ent_t;

    ent_t infl[$];   // accepted fetches not yet in the FIFO
    ent_t fq[$];     // finished responses, head at index 0

    function automatic bit m_ready();
        return reset_n_i && (infl.size() + fq.size() < FE) && !flush_i;
    endfunction

    always @(posedge clk_i or negedge reset_n_i) begin : model
        bit   acc, af_raw, pf_raw;
        int   idx;
        ent_t e;
        ent_t nq[$];
        if (!reset_n_i) begin
            infl.delete();
            fq.delete();
        end else begin
            acc = fetch_v_i && m_ready();
            if (flush_i) begin
                infl.delete();
                fq.delete();
            end else begin
                if (fq.size() > 0 && resp_ready_i) void'(fq.pop_front());
                if (poison_i) begin
                    infl.delete();
                end else begin
                    nq.delete();
                    foreach (infl[i]) begin
                        e = infl[i];
                        if (e.age == 1) begin
                            af_raw = (uncached_mode_i && !uncached_i)
                                  || ((ptag_i >> (PT - DID)) != 0)
                                  || (ptag_i < 28'h80000);
                            pf_raw = translation_en_i && tlb_v_i
                                  && ((priv_i == 2'd1 && pte_u_i)
                                   || (priv_i == 2'd0 && !pte_u_i)
                                   || !pte_x_i);
                            e.itlb = tlb_miss_i;
                            e.af   = !e.itlb && af_raw;
                            e.pf   = !e.itlb && !af_raw && pf_raw;
                        end
                        if (e.age == LAT) begin
                            e.icm  = !(e.itlb || e.af || e.pf) && !cache_data_v_i;
                            e.data = cache_data_i;
                            idx    = int'((e.vaddr >> 2) % LN);
                            for (int l = 0; l < LN; l++) e.lane[l] = (l >= idx);
                            fq.push_back(e);
                        end else begin
                            e.age++;
                            nq.push_back(e);
                        end
                    end
                    infl = nq;
                end
                if (acc) begin
                    e.vaddr = fetch_vaddr_i;
                    e.age   = 1;
                    e.itlb  = 0; e.af = 0; e.pf = 0; e.icm = 0;
                    e.data  = '0;
                    e.lane  = '0;
                    infl.push_back(e);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        check("fetch_ready", 128'(fetch_ready_o), 128'(m_ready()));
        check("resp_v", 128'(resp_v_o), 128'(reset_n_i && fq.size() > 0));
        if (reset_n_i && fq.size() > 0) begin
            check("resp_vaddr", 128'(resp_vaddr_o), 128'(fq[0].vaddr));
            check("resp_data", 128'(resp_data_o), 128'(fq[0].data));
            check("resp_lane_v", 128'(resp_lane_v_o), 128'(fq[0].lane));
            check("resp_flags",
                  128'({resp_itlb_miss_o, resp_instr_access_fault_o,
                        resp_instr_page_fault_o, resp_icache_miss_o}),
                  128'({fq[0].itlb, fq[0].af, fq[0].pf, fq[0].icm}));
        end else if (!reset_n_i) begin
            check("reset_payload",
                  128'({resp_vaddr_o, resp_data_o, resp_lane_v_o, resp_itlb_miss_o,
                        resp_instr_access_fault_o, resp_instr_page_fault_o,
                        resp_icache_miss_o}), 128'(0));
        end
    end

    // ---------------- stimulus ----------------
    bit rand_data = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_data) cache_data_i = {$urandom, $urandom};
    endtask

    task automatic set_defaults();
        tlb_v_i = 1; tlb_miss_i = 0; ptag_i = 28'h80000;
        pte_u_i = 0; pte_x_i = 1; uncached_i = 0; priv_i = 2'd3;
        translation_en_i = 0; uncached_mode_i = 0; cache_data_v_i = 1;
    endtask

    typedef struct {
        logic [PT-1:0] ptag;
        bit            tmiss, ten, pu, px, unc, umode, cv;
        logic [1:0]    priv;
        logic [VA-1:0] va;
        logic [3:0]    exp_flags;  // {itlb, access, page, icache_miss}
        logic [1:0]    exp_lane;
    } frow_t;

    frow_t rows[9];

    initial begin
        rows[0] = '{28'h007FFFF, 0, 0, 0, 1, 0, 0, 1, 2'd3, 39'h80003004, 4'b0100, 2'b10};
        rows[1] = '{28'h0080000, 0, 1, 0, 1, 0, 0, 1, 2'd0, 39'h80003000, 4'b0010, 2'b11};
        rows[2] = '{28'h007FFFF, 1, 1, 0, 0, 0, 0, 0, 2'd0, 39'h80003008, 4'b1000, 2'b11};
        rows[3] = '{28'h0080000, 0, 0, 0, 1, 0, 0, 0, 2'd3, 39'h8000300C, 4'b0001, 2'b10};
        rows[4] = '{28'h2080000, 0, 0, 0, 1, 0, 0, 1, 2'd3, 39'h80003010, 4'b0100, 2'b11};
        rows[5] = '{28'h0080000, 0, 0, 0, 1, 0, 1, 1, 2'd3, 39'h80003014, 4'b0100, 2'b10};
        rows[6] = '{28'h0080000, 0, 1, 1, 1, 0, 0, 0, 2'd1, 39'h80003018, 4'b0010, 2'b11};
        rows[7] = '{28'h0080000, 0, 1, 0, 0, 0, 0, 1, 2'd3, 39'h8000301C, 4'b0010, 2'b10};
        rows[8] = '{28'h0080000, 0, 0, 0, 0, 1, 1, 1, 2'd3, 39'h80003020, 4'b0000, 2'b11};

        set_defaults();
        reset_n_i = 0; fetch_v_i = 0; fetch_vaddr_i = '0; poison_i = 0; flush_i = 0;
        resp_ready_i = 1; cache_data_i = '0;

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_resp_v", 128'(resp_v_o), 128'(0));
        check("rst_fetch_ready", 128'(fetch_ready_o), 128'(0));
        check("rst_data", 128'(resp_data_o), 128'(0));
        #2 reset_n_i = 1;
        #1 check("post_rst_ready", 128'(fetch_ready_o), 128'(1));
        tick();

        // hit
        cache_data_i  = 64'hAAAA_BBBB_CCCC_DDDD;
        fetch_v_i     = 1;
        fetch_vaddr_i = 39'h80000004;
        @(negedge clk_i) check("hit_ready", 128'(fetch_ready_o), 128'(1));
        tick(); fetch_v_i = 0;
        tick();
        @(negedge clk_i) check("hit_not_early", 128'(resp_v_o), 128'(0));
        tick();
        @(negedge clk_i);
        check("hit_resp_v", 128'(resp_v_o), 128'(1));
        check("hit_lane", 128'(resp_lane_v_o), 128'(2'b10));
        check("hit_data", 128'(resp_data_o), 128'(64'hAAAA_BBBB_CCCC_DDDD));
        check("hit_vaddr", 128'(resp_vaddr_o), 128'(39'h80000004));
        check("hit_flags", 128'({resp_itlb_miss_o, resp_instr_access_fault_o,
                                 resp_instr_page_fault_o, resp_icache_miss_o}), 128'(0));
        tick();

        // backpressure
        rand_data = 1;
        resp_ready_i = 0;
        fetch_v_i = 1;
        for (int i = 0; i < 4; i++) begin
            fetch_vaddr_i = 39'h80001000 + 39'(i * 4);
            tick();
        end
        fetch_vaddr_i = 39'h80001010;
        @(negedge clk_i) check("bp_full_ready", 128'(fetch_ready_o), 128'(0));
        repeat (3) tick();
        resp_ready_i = 1;
        @(negedge clk_i) check("bp_head_vaddr", 128'(resp_vaddr_o), 128'(39'h80001000));
        tick();
        resp_ready_i = 0;
        @(negedge clk_i) check("bp_credit_ready", 128'(fetch_ready_o), 128'(1));
        tick();
        fetch_v_i = 0;
        resp_ready_i = 1;
        repeat (8) tick();

        // poison
        fetch_v_i = 1; fetch_vaddr_i = 39'h80002000;
        tick();
        poison_i = 1; fetch_vaddr_i = 39'h80002008;
        tick();
        poison_i = 0; fetch_v_i = 0;
        tick();
        @(negedge clk_i) check("poison_killed", 128'(resp_v_o), 128'(0));
        tick();
        @(negedge clk_i);
        check("poison_survivor_v", 128'(resp_v_o), 128'(1));
        check("poison_survivor_va", 128'(resp_vaddr_o), 128'(39'h80002008));
        repeat (2) tick();

        // fault qualification
        foreach (rows[r]) begin
            ptag_i = rows[r].ptag; tlb_miss_i = rows[r].tmiss;
            translation_en_i = rows[r].ten; pte_u_i = rows[r].pu; pte_x_i = rows[r].px;
            uncached_i = rows[r].unc; uncached_mode_i = rows[r].umode;
            cache_data_v_i = rows[r].cv; priv_i = rows[r].priv;
            fetch_v_i = 1; fetch_vaddr_i = rows[r].va;
            tick();
            fetch_v_i = 0;
            repeat (2) tick();
            @(negedge clk_i);
            check($sformatf("fault_row%0d_flags", r),
                  128'({resp_itlb_miss_o, resp_instr_access_fault_o,
                        resp_instr_page_fault_o, resp_icache_miss_o}),
                  128'(rows[r].exp_flags));
            check($sformatf("fault_row%0d_lane", r), 128'(resp_lane_v_o),
                  128'(rows[r].exp_lane));
            tick();
            set_defaults();
        end

        // flush with two responses queued and two fetches in flight
        resp_ready_i = 0;
        fetch_v_i = 1; fetch_vaddr_i = 39'h80004000; tick();
        fetch_vaddr_i = 39'h80004004; tick();
        fetch_v_i = 0;
        repeat (3) tick();
        fetch_v_i = 1; fetch_vaddr_i = 39'h80004008; tick();
        fetch_vaddr_i = 39'h8000400C; tick();
        fetch_v_i = 0;
        flush_i = 1; resp_ready_i = 1;
        @(negedge clk_i) check("flush_ready_low", 128'(fetch_ready_o), 128'(0));
        tick();
        flush_i = 0;
        @(negedge clk_i);
        check("flush_resp_v", 128'(resp_v_o), 128'(0));
        check("flush_ready", 128'(fetch_ready_o), 128'(1));
        repeat (4) tick();

        // asynchronous reset mid-stream
        resp_ready_i = 0;
        fetch_v_i = 1;
        for (int i = 0; i < 3; i++) begin
            fetch_vaddr_i = 39'h80005000 + 39'(i * 4);
            tick();
        end
        fetch_v_i = 0;
        repeat (3) tick();
        #2 reset_n_i = 0;
        #1;
        check("areset_resp_v", 128'(resp_v_o), 128'(0));
        check("areset_ready", 128'(fetch_ready_o), 128'(0));
        repeat (2) tick();
        #2 reset_n_i = 1;
        resp_ready_i = 1;
        repeat (5) tick();
        fetch_v_i = 1; fetch_vaddr_i = 39'h80006000;
        tick();
        fetch_v_i = 0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
